clock_divider_mc: RTL
=====================

Name: clock_divider_mc

Overview:
Multi-channel programmable clock divider. It is the parametrised successor of the single-channel scale×constant divider.
- Each channel divides clk_in by period P = scale×PRESCALE and produces a ~50 % duty output plus a one-cycle rising-edge tick.
- Adds per-channel enable, glitch-free shadowed reload at period boundaries, correct odd-period handling, and a global phase-align strobe.
- Sits between the board clock and downstream blocks needing slow, mutually phase-aligned clocks/strobes.

Parameters:
CHANNELS, 2, number of independent divider channels
WIDTH, 8, width of each channel's scale field
CNT_W, 32, width of period/counter arithmetic
PRESCALE, 258850, constant multiplier applied to scale (benches override to 1)

Ports:
clk_in  input  1  source clock; all logic on posedge
nrst  input  1  synchronous active-low reset
en  input  CHANNELS  per-channel run enable
load  input  CHANNELS  per-channel strobe: capture scale slice into shadow register
scale  input  CHANNELS*WIDTH  channel i uses bits [i*WIDTH +: WIDTH]
align  input  1  global strobe: restart all channel phases together
clk_out  output  CHANNELS  divided clock per channel
tick  output  CHANNELS  one-cycle pulse coinciding with each clk_out rising edge

Behaviour:
- Period arithmetic: P = scale_i × PRESCALE, computed at CNT_W bits, upper bits truncated. H (high cycles) = P − floor(P/2), so an odd P is high one cycle longer than low.
- Per-channel state: act_p (active period), pend_p (shadow), pend flag, count (CNT_W), out_q, tick_q.
- Reset (nrst=0 at clk edge):
  - act_p <= scale_i×PRESCALE; count <= 0; out_q <= 0; tick_q <= 0; pend <= 0.
  - clk_out in divide mode and tick are 0 during and after reset until the first enabled cycle.
- Bypass: act_p < 2 ⇒ clk_out_i = clk_in combinationally. tick_i = en_i registered (high every cycle while enabled). Counter is held at 0.
- Divide mode, en_i=1, no align, one action per edge:
  - out_q <= (count < H); tick_q <= (count == 0).
  - count <= (count == act_p−1) ? 0 : count+1.
  - First enabled edge after reset or restart: out_q=1, tick=1. Output period is exactly act_p cycles, high for H.
- en_i=0: count <= 0; out_q <= 0; tick_q <= 0. Re-enable restarts the phase from count 0 (no runt high pulse).
- Reload:
  - load_i sets pend_p <= scale_i×PRESCALE and pend <= 1. A second load before application overwrites pend_p.
  - Pending value is applied (act_p <= pend_p, pend <= 0) on the first of:
    - a boundary edge (en_i=1 and count == act_p−1);
    - any edge with en_i=0;
    - any edge in bypass;
    - an align edge.
  - load_i in the same cycle as an application point: the freshly captured value is applied at that edge directly.
  - The old period always completes fully; no shortened or stretched phase.
- align=1: for every channel count <= 0, out_q <= 0, tick_q <= 0, pending loads applied. Overrides en and boundary logic that cycle. Next enabled edge gives out_q=1/tick=1 on all enabled divide-mode channels simultaneously.
- Priority per edge: nrst > align > load/en/count.
- Switching between bypass and divide mode may glitch clk_out. This is acceptable; consumers switch only while en_i=0.
- Reset mid-operation: immediate return to the reset state above, regardless of pending loads or phase.

Test Plan:
- PRESCALE=1, scale0=4, en0=1 after reset → clk_out0 pattern 1,1,0,0 repeating; tick0 on each first high cycle; period 4.
- scale1=5 → clk_out1 high 3, low 2 cycles; tick1 every 5 cycles.
- ch0 running at 4, load0 with scale=6 mid-period → current 4-cycle period completes intact, then 3 high/3 low; no runt pulse.
- Channels at periods 4 and 6 with arbitrary phase, pulse align → both outputs 0 that cycle, then tick0 and tick1 asserted together on the next edge.
- scale0=0 and scale0=1 → clk_out0 follows clk_in; en0 toggled low mid-period → clk_out0=0 next edge, and re-enable restarts with 1,1,0,0.
- Assert nrst mid-period with load pending → outputs 0, pending discarded, act_p = current scale×PRESCALE, first enabled edge gives tick=1.

Source files
------------

// File: rtl/clock_divider_mc.sv
// Multi-channel clock divider: each channel divides clk_in by scale*PRESCALE with ~50% duty plus a rising-edge tick.
// Latency: outputs registered one edge after inputs (bypass clk_out is combinational); no backpressure.
module clock_divider_mc #(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 8,
    parameter int CNT_W    = 32,
    parameter int PRESCALE = 258850
) (
    input  logic                      clk_in,
    input  logic                      nrst,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS-1:0]       load,
    input  logic [CHANNELS*WIDTH-1:0] scale,
    input  logic                      align,
    output logic [CHANNELS-1:0]       clk_out,
    output logic [CHANNELS-1:0]       tick
);

    localparam logic [CNT_W-1:0] PRE = CNT_W'(PRESCALE);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [CNT_W-1:0] w_new_p;
        logic [CNT_W-1:0] w_half;
        logic [CNT_W-1:0] r_act_p;
        logic [CNT_W-1:0] r_pend_p;
        logic [CNT_W-1:0] r_count;
        logic             r_pend;
        logic             r_out_q;
        logic             r_tick_q;
        logic             w_bypass;
        logic             w_boundary;
        logic             w_apply;

        assign w_new_p    = CNT_W'(scale[g*WIDTH +: WIDTH]) * PRE;
        // Odd periods spend the extra cycle high.
        assign w_half     = r_act_p - (r_act_p >> 1);
        assign w_bypass   = r_act_p < CNT_W'(2);
        assign w_boundary = en[g] && (r_count == r_act_p - CNT_W'(1));
        assign w_apply    = align || !en[g] || w_bypass || w_boundary;

        always_ff @(posedge clk_in) begin
            if (!nrst) begin
                r_act_p  <= w_new_p;
                r_pend_p <= '0;
                r_pend   <= 1'b0;
                r_count  <= '0;
                r_out_q  <= 1'b0;
                r_tick_q <= 1'b0;
            end else begin
                // Shadow reload: a load coinciding with an application point wins directly.
                if (load[g]) begin
                    r_pend_p <= w_new_p;
                end
                if (w_apply) begin
                    r_pend <= 1'b0;
                    if (load[g]) begin
                        r_act_p <= w_new_p;
                    end else if (r_pend) begin
                        r_act_p <= r_pend_p;
                    end
                end else if (load[g]) begin
                    r_pend <= 1'b1;
                end

                if (align) begin
                    r_count  <= '0;
                    r_out_q  <= 1'b0;
                    r_tick_q <= 1'b0;
                end else if (w_bypass) begin
                    r_count  <= '0;
                    r_out_q  <= 1'b0;
                    r_tick_q <= en[g];
                end else if (!en[g]) begin
                    r_count  <= '0;
                    r_out_q  <= 1'b0;
                    r_tick_q <= 1'b0;
                end else begin
                    r_out_q  <= (r_count < w_half);
                    r_tick_q <= (r_count == '0);
                    r_count  <= w_boundary ? '0 : r_count + CNT_W'(1);
                end
            end
        end

        // Periods below 2 cannot be divided; pass the source clock through.
        assign clk_out[g] = w_bypass ? clk_in : r_out_q;
        assign tick[g]    = r_tick_q;
    end

endmodule
